cube_axil_regs: RTL and testbench

CUBE_AXIL_REGS -- requirements
Module: cube_axil_regs

---
 rtl/cube_axil_regs.sv | 203 ++++++++++++++++++++
 tb/tb_cube_axil_regs.sv | 427 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cube_axil_regs.sv
// cube_axil_regs: AXI4-Lite slave exposing four 32-bit registers.
// A committed write of bit0=1 into REG3 launches a 96-bit command built from
// {REG2, REG1, REG0}. The command is held on cmd_valid/cmd_data until the
// downstream consumer accepts it. Every AXI output comes straight from a flop.
module cube_axil_regs #(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 4
) (
   input  logic                              s00_axi_aclk,
   input  logic                              s00_axi_areset,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s00_axi_awaddr,
   input  logic [2:0]                        s00_axi_awprot,
   input  logic                              s00_axi_awvalid,
   output logic                              s00_axi_awready,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]     s00_axi_wdata,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   s00_axi_wstrb,
   input  logic                              s00_axi_wvalid,
   output logic                              s00_axi_wready,
   output logic [1:0]                        s00_axi_bresp,
   output logic                              s00_axi_bvalid,
   input  logic                              s00_axi_bready,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s00_axi_araddr,
   input  logic [2:0]                        s00_axi_arprot,
   input  logic                              s00_axi_arvalid,
   output logic                              s00_axi_arready,
   output logic [C_S_AXI_DATA_WIDTH-1:0]     s00_axi_rdata,
   output logic [1:0]                        s00_axi_rresp,
   output logic                              s00_axi_rvalid,
   input  logic                              s00_axi_rready,
   output logic                              cmd_valid,
   input  logic                              cmd_ready,
   output logic [3*C_S_AXI_DATA_WIDTH-1:0]   cmd_data
);

   localparam int DW = C_S_AXI_DATA_WIDTH;
   localparam int NB = DW / 8;
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   // Write-address and write-data holding buffers (one entry each)
   logic          aw_full_q, aw_full_d;
   logic [1:0]    aw_idx_q, aw_idx_d;
   logic          w_full_q, w_full_d;
   logic [DW-1:0] w_data_q, w_data_d;
   logic [NB-1:0] w_strb_q, w_strb_d;

   // Registered AXI handshake/response state
   logic          awready_q, awready_d;
   logic          wready_q, wready_d;
   logic          bvalid_q, bvalid_d;
   logic [1:0]    bresp_q, bresp_d;
   logic          arready_q, arready_d;
   logic          rvalid_q, rvalid_d;
   logic [DW-1:0] rdata_q, rdata_d;

   // Command output state
   logic            cmd_valid_q, cmd_valid_d;
   logic [3*DW-1:0] cmd_data_q, cmd_data_d;

   // Register file
   logic [DW-1:0] regs_q [4];
   logic [DW-1:0] regs_d [4];

   logic [DW-1:0] wmask;
   logic          commit;
   logic          launch;
   logic          cmd_free;

   // Address bits [1:0] and the protection fields carry no meaning here
   logic unused_ok;
   assign unused_ok = ^{s00_axi_awprot, s00_axi_arprot,
                        s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

   // Expand byte strobes from the W buffer into a bit mask
   genvar gi;
   generate
      for (gi = 0; gi < NB; gi++) begin : g_wmask
         assign wmask[8*gi +: 8] = {8{w_strb_q[gi]}};
      end
   endgenerate

   // A write commits in the cycle both buffers hold an entry
   assign commit   = aw_full_q && w_full_q;
   assign launch   = commit && (aw_idx_q == 2'd3) && w_strb_q[0] && w_data_q[0];
   assign cmd_free = !cmd_valid_q || cmd_ready;

   // Next-state logic for buffers, register file, responses and command
   always_comb begin
      aw_full_d   = aw_full_q;
      aw_idx_d    = aw_idx_q;
      w_full_d    = w_full_q;
      w_data_d    = w_data_q;
      w_strb_d    = w_strb_q;
      bvalid_d    = bvalid_q;
      bresp_d     = bresp_q;
      rvalid_d    = rvalid_q;
      rdata_d     = rdata_q;
      cmd_valid_d = cmd_valid_q;
      cmd_data_d  = cmd_data_q;
      for (int i = 0; i < 4; i++) begin
         regs_d[i] = regs_q[i];
      end

      // Capture AW and W independently into their buffers
      if (s00_axi_awvalid && awready_q) begin
         aw_full_d = 1'b1;
         aw_idx_d  = s00_axi_awaddr[3:2];
      end
      if (s00_axi_wvalid && wready_q) begin
         w_full_d = 1'b1;
         w_data_d = s00_axi_wdata;
         w_strb_d = s00_axi_wstrb;
      end

      // Commit merges enabled bytes, empties both buffers and raises B.
      // A launch blocked by an unaccepted command still updates REG3.
      if (commit) begin
         regs_d[aw_idx_q] = (regs_q[aw_idx_q] & ~wmask) | (w_data_q & wmask);
         aw_full_d = 1'b0;
         w_full_d  = 1'b0;
         bvalid_d  = 1'b1;
         bresp_d   = (launch && !cmd_free) ? RESP_SLVERR : RESP_OKAY;
      end else if (bvalid_q && s00_axi_bready) begin
         bvalid_d = 1'b0;
      end

      // Command drains on acceptance; a fresh launch in the same cycle reloads it
      if (cmd_valid_q && cmd_ready) begin
         cmd_valid_d = 1'b0;
      end
      if (launch && cmd_free) begin
         cmd_valid_d = 1'b1;
         cmd_data_d  = {regs_d[2], regs_d[1], regs_d[0]};
      end

      // Reads sample the pre-commit register value
      if (rvalid_q && s00_axi_rready) begin
         rvalid_d = 1'b0;
      end
      if (s00_axi_arvalid && arready_q) begin
         rvalid_d = 1'b1;
         rdata_d  = regs_q[s00_axi_araddr[3:2]];
      end

      // Ready flags are registered versions of the next buffer/response state
      awready_d = !aw_full_d && !bvalid_d;
      wready_d  = !w_full_d && !bvalid_d;
      arready_d = !rvalid_d;
   end

   // State registers with asynchronous clear
   always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
      if (s00_axi_areset) begin
         aw_full_q   <= 1'b0;
         aw_idx_q    <= '0;
         w_full_q    <= 1'b0;
         w_data_q    <= '0;
         w_strb_q    <= '0;
         awready_q   <= 1'b0;
         wready_q    <= 1'b0;
         bvalid_q    <= 1'b0;
         bresp_q     <= RESP_OKAY;
         arready_q   <= 1'b0;
         rvalid_q    <= 1'b0;
         rdata_q     <= '0;
         cmd_valid_q <= 1'b0;
         cmd_data_q  <= '0;
         for (int i = 0; i < 4; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         aw_full_q   <= aw_full_d;
         aw_idx_q    <= aw_idx_d;
         w_full_q    <= w_full_d;
         w_data_q    <= w_data_d;
         w_strb_q    <= w_strb_d;
         awready_q   <= awready_d;
         wready_q    <= wready_d;
         bvalid_q    <= bvalid_d;
         bresp_q     <= bresp_d;
         arready_q   <= arready_d;
         rvalid_q    <= rvalid_d;
         rdata_q     <= rdata_d;
         cmd_valid_q <= cmd_valid_d;
         cmd_data_q  <= cmd_data_d;
         for (int i = 0; i < 4; i++) begin
            regs_q[i] <= regs_d[i];
         end
      end
   end

   assign s00_axi_awready = awready_q;
   assign s00_axi_wready  = wready_q;
   assign s00_axi_bvalid  = bvalid_q;
   assign s00_axi_bresp   = bresp_q;
   assign s00_axi_arready = arready_q;
   assign s00_axi_rvalid  = rvalid_q;
   assign s00_axi_rdata   = rdata_q;
   assign s00_axi_rresp   = RESP_OKAY;
   assign cmd_valid       = cmd_valid_q;
   assign cmd_data        = cmd_data_q;

endmodule

// File: tb/tb_cube_axil_regs.sv
// tb_cube_axil_regs: directed table, hand-written corner sequences and a
// randomized phase checked against a register-array reference model.
module tb_cube_axil_regs;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  awaddr;
   logic [2:0]  awprot;
   logic        awvalid;
   logic        awready;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wvalid;
   logic        wready;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready;
   logic [3:0]  araddr;
   logic [2:0]  arprot;
   logic        arvalid;
   logic        arready;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rvalid;
   logic        rready;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [95:0] cmd_data;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   cube_axil_regs #(
      .C_S_AXI_DATA_WIDTH(32),
      .C_S_AXI_ADDR_WIDTH(4)
   ) dut (
      .s00_axi_aclk   (clk),
      .s00_axi_areset (rst),
      .s00_axi_awaddr (awaddr),
      .s00_axi_awprot (awprot),
      .s00_axi_awvalid(awvalid),
      .s00_axi_awready(awready),
      .s00_axi_wdata  (wdata),
      .s00_axi_wstrb  (wstrb),
      .s00_axi_wvalid (wvalid),
      .s00_axi_wready (wready),
      .s00_axi_bresp  (bresp),
      .s00_axi_bvalid (bvalid),
      .s00_axi_bready (bready),
      .s00_axi_araddr (araddr),
      .s00_axi_arprot (arprot),
      .s00_axi_arvalid(arvalid),
      .s00_axi_arready(arready),
      .s00_axi_rdata  (rdata),
      .s00_axi_rresp  (rresp),
      .s00_axi_rvalid (rvalid),
      .s00_axi_rready (rready),
      .cmd_valid      (cmd_valid),
      .cmd_ready      (cmd_ready),
      .cmd_data       (cmd_data)
   );

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   task automatic timeout(input string name);
      n_checks++;
      $display("FAIL %s: timed out waiting for handshake", name);
   endtask

   // Full AXI write: AW and W together, then collect B
   task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                            output logic [1:0] resp, output bit ok);
      bit aw_hs;
      bit w_hs;
      bit aw_done = 0;
      bit w_done  = 0;
      ok = 0;
      resp = 2'bxx;
      awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
      for (int c = 0; c < 40 && !(aw_done && w_done); c++) begin
         @(negedge clk);
         aw_hs = awvalid && awready;
         w_hs  = wvalid && wready;
         @(posedge clk); #1;
         if (aw_hs) begin aw_done = 1; awvalid = 1'b0; end
         if (w_hs)  begin w_done = 1;  wvalid = 1'b0; end
      end
      awvalid = 1'b0; wvalid = 1'b0;
      if (aw_done && w_done) begin
         bready = 1'b1;
         for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bvalid) begin
               resp = bresp; ok = 1;
               @(posedge clk); #1;
               break;
            end
         end
         bready = 1'b0;
      end
      $display("wr addr=0x%0h data=0x%08h strb=%b resp=%b", a, d, s, resp);
   endtask

   // Full AXI read: AR handshake, then collect R
   task automatic axi_read(input logic [3:0] a, output logic [31:0] d, output logic [1:0] resp,
                           output bit ok);
      bit ar_done = 0;
      bit ar_hs;
      ok = 0;
      d = 'x;
      resp = 2'bxx;
      araddr = a; arvalid = 1'b1;
      for (int c = 0; c < 40 && !ar_done; c++) begin
         @(negedge clk);
         ar_hs = arvalid && arready;
         @(posedge clk); #1;
         if (ar_hs) begin ar_done = 1; arvalid = 1'b0; end
      end
      arvalid = 1'b0;
      if (ar_done) begin
         rready = 1'b1;
         for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (rvalid) begin
               d = rdata; resp = rresp; ok = 1;
               @(posedge clk); #1;
               break;
            end
         end
         rready = 1'b0;
      end
      $display("rd addr=0x%0h data=0x%08h resp=%b", a, d, resp);
   endtask

   task automatic write_chk(input string name, input logic [3:0] a, input logic [31:0] d,
                            input logic [3:0] s, input logic [1:0] exp_resp);
      logic [1:0] r;
      bit ok;
      axi_write(a, d, s, r, ok);
      if (!ok) timeout(name);
      else check(name, r, exp_resp);
   endtask

   task automatic read_chk(input string name, input logic [3:0] a, input logic [31:0] exp);
      logic [31:0] d;
      logic [1:0] r;
      bit ok;
      axi_read(a, d, r, ok);
      if (!ok) timeout(name);
      else begin
         check(name, d, exp);
         check({name, "_resp"}, r, 2'b00);
      end
   endtask

   typedef struct {
      bit          is_wr;
      logic [3:0]  addr;
      logic [31:0] data;
      logic [3:0]  strb;
      logic [31:0] exp_rdata;
      logic [1:0]  exp_resp;
   } vec_t;

   vec_t tbl[12];

   // Reference model state for the randomized phase
   logic [31:0] m_regs [4];
   bit          m_cmd_valid;
   logic [95:0] m_cmd_data;

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      bit got;
      logic [1:0] r;
      bit ok;

      rst = 1'b1;
      awaddr = 0; awprot = 0; awvalid = 0; wdata = 0; wstrb = 0; wvalid = 0; bready = 0;
      araddr = 0; arprot = 0; arvalid = 0; rready = 0; cmd_ready = 0;

      // ---------------- reset state ----------------
      repeat (3) @(posedge clk);
      #1;
      check("rst_awready", awready, 0);
      check("rst_wready", wready, 0);
      check("rst_arready", arready, 0);
      check("rst_bvalid", bvalid, 0);
      check("rst_rvalid", rvalid, 0);
      check("rst_cmd_valid", cmd_valid, 0);
      check("rst_cmd_data", cmd_data, 0);
      check("rst_rdata", rdata, 0);
      check("rst_bresp", bresp, 0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      check("rel_awready", awready, 1);
      check("rel_wready", wready, 1);
      check("rel_arready", arready, 1);

      // ---------------- table-driven basic writes / reads / strobes ----------------
      tbl[0]  = '{1'b1, 4'h0, 32'h1,        4'hF,    32'h0,        2'b00};
      tbl[1]  = '{1'b1, 4'h4, 32'h2,        4'hF,    32'h0,        2'b00};
      tbl[2]  = '{1'b1, 4'h8, 32'h3,        4'hF,    32'h0,        2'b00};
      tbl[3]  = '{1'b1, 4'hC, 32'h4,        4'hF,    32'h0,        2'b00};
      tbl[4]  = '{1'b0, 4'h0, 32'h0,        4'h0,    32'h1,        2'b00};
      tbl[5]  = '{1'b0, 4'h4, 32'h0,        4'h0,    32'h2,        2'b00};
      tbl[6]  = '{1'b0, 4'h8, 32'h0,        4'h0,    32'h3,        2'b00};
      tbl[7]  = '{1'b0, 4'hC, 32'h0,        4'h0,    32'h4,        2'b00};
      tbl[8]  = '{1'b1, 4'h4, 32'h0,        4'hF,    32'h0,        2'b00};
      tbl[9]  = '{1'b1, 4'h4, 32'hAABBCCDD, 4'b0101, 32'h0,        2'b00};
      tbl[10] = '{1'b0, 4'h4, 32'h0,        4'h0,    32'h00BB00DD, 2'b00};
      tbl[11] = '{1'b0, 4'h6, 32'h0,        4'h0,    32'h00BB00DD, 2'b00};
      for (int i = 0; i < 12; i++) begin
         if (tbl[i].is_wr)
            write_chk($sformatf("tbl%0d_bresp", i), tbl[i].addr, tbl[i].data, tbl[i].strb,
                      tbl[i].exp_resp);
         else
            read_chk($sformatf("tbl%0d_rdata", i), tbl[i].addr, tbl[i].exp_rdata);
      end
      check("tbl_no_cmd", cmd_valid, 0);

      // ---------------- W three cycles ahead of AW, B held off 5 cycles ----------------
      wdata = 32'h12345678; wstrb = 4'hF; awaddr = 4'h0; wvalid = 1'b1;
      @(negedge clk);
      check("early_w_wready", wready, 1);
      @(posedge clk); #1;
      wvalid = 1'b0;
      repeat (2) begin
         @(negedge clk);
         check("early_w_wready_low", wready, 0);
         check("early_w_awready_high", awready, 1);
         @(posedge clk); #1;
      end
      awvalid = 1'b1;
      @(negedge clk);
      check("late_aw_awready", awready, 1);
      @(posedge clk); #1;
      awvalid = 1'b0;
      got = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (bvalid) begin got = 1; break; end
      end
      if (!got) timeout("hold_b_bvalid");
      for (int i = 0; i < 5; i++) begin
         if (i > 0) @(negedge clk);
         check("hold_b_bvalid", bvalid, 1);
         check("hold_b_awready", awready, 0);
         check("hold_b_wready", wready, 0);
         check("hold_b_bresp", bresp, 0);
      end
      @(posedge clk); #1;
      bready = 1'b1;
      @(negedge clk);
      check("hold_b_bvalid_at_ready", bvalid, 1);
      @(posedge clk); #1;
      bready = 1'b0;
      @(negedge clk);
      check("after_b_bvalid", bvalid, 0);
      check("after_b_awready", awready, 1);
      check("after_b_wready", wready, 1);
      @(negedge clk);
      check("after_b_no_second_commit", bvalid, 0);
      @(posedge clk); #1;
      read_chk("hold_b_readback", 4'h0, 32'h12345678);

      // ---------------- command launch and blocked launch ----------------
      cmd_ready = 1'b0;
      write_chk("cmd_wr_reg0", 4'h0, 32'h10, 4'hF, 2'b00);
      write_chk("cmd_wr_reg1", 4'h4, 32'h20, 4'hF, 2'b00);
      write_chk("cmd_wr_reg2", 4'h8, 32'h30, 4'hF, 2'b00);
      write_chk("cmd_launch_bresp", 4'hC, 32'h1, 4'hF, 2'b00);
      check("cmd_launch_valid", cmd_valid, 1);
      check("cmd_launch_data", cmd_data, 96'h00000030_00000020_00000010);
      write_chk("cmd_blocked_bresp", 4'hC, 32'h1, 4'hF, 2'b10);
      check("cmd_blocked_valid", cmd_valid, 1);
      check("cmd_blocked_data", cmd_data, 96'h00000030_00000020_00000010);
      cmd_ready = 1'b1;
      @(negedge clk);
      check("cmd_ready_valid_before_edge", cmd_valid, 1);
      @(posedge clk); #1;
      cmd_ready = 1'b0;
      @(negedge clk);
      check("cmd_drained", cmd_valid, 0);
      @(posedge clk); #1;

      // ---------------- write commit and read of same register in one cycle ----------------
      awaddr = 4'h8; wdata = 32'h55; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
      @(negedge clk);
      check("same_cyc_awready", awready, 1);
      check("same_cyc_wready", wready, 1);
      @(posedge clk); #1;
      awvalid = 1'b0; wvalid = 1'b0;
      araddr = 4'h8; arvalid = 1'b1;
      @(negedge clk);
      check("same_cyc_arready", arready, 1);
      @(posedge clk); #1;
      arvalid = 1'b0;
      rready = 1'b1;
      got = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (rvalid) begin got = 1; break; end
      end
      if (!got) timeout("same_cyc_rdata");
      else check("same_cyc_rdata", rdata, 32'h30);
      $display("rd addr=0x8 data=0x%08h resp=%b (concurrent with write)", rdata, rresp);
      @(posedge clk); #1;
      rready = 1'b0;
      bready = 1'b1;
      got = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (bvalid) begin got = 1; break; end
      end
      if (!got) timeout("same_cyc_bresp");
      else check("same_cyc_bresp", bresp, 0);
      $display("wr addr=0x8 data=0x00000055 strb=1111 resp=%b (concurrent with read)", bresp);
      @(posedge clk); #1;
      bready = 1'b0;
      read_chk("same_cyc_followup", 4'h8, 32'h55);

      // ---------------- reset during pending B and command ----------------
      cmd_ready = 1'b0;
      awaddr = 4'hC; wdata = 32'h1; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
      @(posedge clk); #1;
      awvalid = 1'b0; wvalid = 1'b0;
      got = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (bvalid) begin got = 1; break; end
      end
      if (!got) timeout("mid_rst_bvalid");
      check("mid_rst_cmd_valid_pre", cmd_valid, 1);
      #2 rst = 1'b1;
      #1;
      check("mid_rst_bvalid", bvalid, 0);
      check("mid_rst_cmd_valid", cmd_valid, 0);
      check("mid_rst_cmd_data", cmd_data, 0);
      check("mid_rst_awready", awready, 0);
      $display("reset asserted with bvalid and cmd_valid pending");
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      check("mid_rst_rel_awready", awready, 1);
      check("mid_rst_rel_wready", wready, 1);
      check("mid_rst_rel_arready", arready, 1);
      for (int i = 0; i < 4; i++) read_chk($sformatf("mid_rst_reg%0d", i), 4'(i * 4), 32'h0);

      // ---------------- randomized phase against reference model ----------------
      for (int i = 0; i < 4; i++) m_regs[i] = 32'h0;
      m_cmd_valid = 0;
      m_cmd_data  = '0;
      for (int n = 0; n < 120; n++) begin
         int op;
         int idx;
         logic [3:0]  a;
         logic [31:0] d;
         logic [3:0]  s;
         logic [31:0] rd;
         logic [1:0]  exp_r;
         op  = $urandom_range(0, 5);
         idx = $urandom_range(0, 3);
         a   = {2'(idx), 2'($urandom_range(0, 3))};
         if (op == 0) begin
            cmd_ready = 1'b1;
            @(posedge clk); #1;
            cmd_ready = 1'b0;
            m_cmd_valid = 0;
            $display("cmd drain pulse");
            @(negedge clk);
            check("rnd_drain_cmd_valid", cmd_valid, 1'(m_cmd_valid));
            @(posedge clk); #1;
         end else if (op <= 2) begin
            axi_read(a, rd, r, ok);
            if (!ok) timeout("rnd_read");
            else begin
               check($sformatf("rnd_read_reg%0d", idx), rd, m_regs[idx]);
               check("rnd_read_resp", r, 2'b00);
            end
         end else begin
            d = $urandom;
            s = 4'($urandom_range(0, 15));
            if (idx == 3 && $urandom_range(0, 3) != 0) begin
               d[0] = 1'b1;
               s[0] = 1'b1;
            end
            for (int b = 0; b < 4; b++)
               if (s[b]) m_regs[idx][8*b +: 8] = d[8*b +: 8];
            exp_r = 2'b00;
            if (idx == 3 && s[0] && d[0]) begin
               if (!m_cmd_valid) begin
                  m_cmd_valid = 1;
                  m_cmd_data  = {m_regs[2], m_regs[1], m_regs[0]};
               end else begin
                  exp_r = 2'b10;
               end
            end
            axi_write(a, d, s, r, ok);
            if (!ok) timeout("rnd_write");
            else begin
               check("rnd_write_bresp", r, exp_r);
               check("rnd_write_cmd_valid", cmd_valid, 1'(m_cmd_valid));
               if (m_cmd_valid) check("rnd_write_cmd_data", cmd_data, m_cmd_data);
            end
         end
      end
      for (int i = 0; i < 4; i++) read_chk($sformatf("rnd_final_reg%0d", i), 4'(i * 4), m_regs[i]);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
